// File: rtl/cskip_pkg.sv
// Shared definitions for the carry-skip frame accumulator.
// Contents: FSM state encoding and the byte width of the low-order adder.
package cskip_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/CSkipA8.sv
// CSkipA8: 8-bit combinational carry-skip adder, carry-in tied to zero.
// Two 4-bit ripple blocks. A block whose bits all propagate forwards its
// incoming carry directly instead of waiting for the ripple.
// Ports:
//   sum  out 8  a + b modulo 256
//   cout out 1  carry out of bit 7
//   a    in  8  addend
//   b    in  8  addend
module CSkipA8
    import cskip_pkg::*;
(
    output logic [BYTE_W-1:0] sum,
    output logic              cout,
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b
);

    localparam int unsigned BlkW   = 4;
    localparam int unsigned NumBlk = BYTE_W / BlkW;

    logic carry;
    logic blk_cin;
    logic blk_p;
    logic rc;
    logic p;

    always_comb begin
        sum     = '0;
        carry   = 1'b0;
        blk_cin = 1'b0;
        blk_p   = 1'b0;
        rc      = 1'b0;
        p       = 1'b0;
        for (int blk = 0; blk < NumBlk; blk++) begin
            blk_cin = carry;
            rc      = carry;
            blk_p   = 1'b1;
            for (int i = 0; i < BlkW; i++) begin
                p                   = a[blk*BlkW+i] ^ b[blk*BlkW+i];
                sum[blk*BlkW+i]     = p ^ rc;
                rc                  = (a[blk*BlkW+i] & b[blk*BlkW+i]) | (p & rc);
                blk_p               = blk_p & p;
            end
            // Skip path: a fully propagating block passes its carry-in through.
            carry = blk_p ? blk_cin : rc;
        end
        cout = carry;
    end

endmodule

// File: rtl/cskip_accum8.sv
// cskip_accum8: frame accumulator built around CSkipA8.
// Sums frame_len 8-bit samples into an ACC_W-bit result. The low byte is
// added by CSkipA8; its carry-out increments the upper field. One result
// per frame is offered on a valid/ready handshake.
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   start      in  1      begin a frame (honoured only when idle)
//   frame_len  in  CNT_W  samples in the frame, sampled with start
//   in_valid   in  1      in_data valid
//   in_ready   out 1      sample accepted this cycle when in_valid
//   in_data    in  8      sample
//   out_valid  out 1      result valid
//   out_ready  in  1      consumer takes the result
//   out_sum    out ACC_W  frame sum modulo 2**ACC_W
//   out_ovf    out 1      sum exceeded 2**ACC_W-1 during the frame
//   busy       out 1      frame in progress or result pending
module cskip_accum8
    import cskip_pkg::*;
#(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  frame_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    localparam int unsigned UpW = ACC_W - BYTE_W;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   count_q;
    logic               ovf_q;

    logic [BYTE_W-1:0]  lo_sum;
    logic               lo_cout;
    logic [UpW-1:0]     upper;
    logic [UpW-1:0]     upper_nxt;
    logic               ovf_set;
    logic               beat;

    CSkipA8 u_adder (
        .sum  (lo_sum),
        .cout (lo_cout),
        .a    (acc_q[BYTE_W-1:0]),
        .b    (in_data)
    );

    assign upper     = acc_q[ACC_W-1:BYTE_W];
    assign upper_nxt = lo_cout ? upper + 1'b1 : upper;
    // Carry into an all-ones upper field wraps the accumulator.
    assign ovf_set   = lo_cout & (&upper);
    assign beat      = (state_q == ST_ACCUM) & in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (frame_len == '0) ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat && count_q == CNT_W'(1)) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= frame_len;
        end else if (beat) begin
            acc_q   <= {upper_nxt, lo_sum};
            ovf_q   <= ovf_q | ovf_set;
            count_q <= count_q - 1'b1;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_ACCUM);
        out_valid = (state_q == ST_HOLD);
        busy      = (state_q == ST_ACCUM) | (state_q == ST_HOLD);
        // Result is presented only while held so idle outputs read as zero.
        out_sum   = (state_q == ST_HOLD) ? acc_q : '0;
        out_ovf   = (state_q == ST_HOLD) & ovf_q;
    end

endmodule

// File: tb/tb_cskip_accum8.sv
module tb_cskip_accum8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  frame_len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_sum;
    logic        out_ovf;
    logic        busy;

    logic        in_ready9;
    logic        out_valid9;
    logic [8:0]  out_sum9;
    logic        out_ovf9;
    logic        busy9;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cskip_accum8 #(.ACC_W(16), .CNT_W(8)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frame_len (frame_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    // Narrow instance shares the stimulus to exercise wrap and overflow.
    cskip_accum8 #(.ACC_W(9), .CNT_W(8)) dut9 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frame_len (frame_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready9),
        .in_data   (in_data),
        .out_valid (out_valid9),
        .out_ready (out_ready),
        .out_sum   (out_sum9),
        .out_ovf   (out_ovf9),
        .busy      (busy9)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples both happen 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input logic [7:0] len);
        start     = 1'b1;
        frame_len = len;
        step();
        start     = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] t2 [7];
        t2 = '{8'h58, 8'h3D, 8'hCA, 8'hA6, 8'hF3, 8'hF3, 8'h5C};

        rst = 1'b1; start = 1'b0; frame_len = 8'd0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        step();
        step();
        check_eq("rst_in_ready",  32'(in_ready),  32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_sum",   32'(out_sum),   32'd0);
        check_eq("rst_busy",      32'(busy),      32'd0);
        rst = 1'b0;
        step();

        // 1: two beats of 0xA0
        begin_frame(8'd2);
        check_eq("t1_in_ready", 32'(in_ready), 32'd1);
        check_eq("t1_busy",     32'(busy),     32'd1);
        send_beat(8'hA0);
        check_eq("t1_mid_valid", 32'(out_valid), 32'd0);
        send_beat(8'hA0);
        check_eq("t1_out_valid", 32'(out_valid), 32'd1);
        check_eq("t1_out_sum",   32'(out_sum),   32'h0140);
        check_eq("t1_out_ovf",   32'(out_ovf),   32'd0);
        check_eq("t1_in_ready0", 32'(in_ready),  32'd0);
        drain();
        check_eq("t1_idle_valid", 32'(out_valid), 32'd0);

        // 2: seven beats with gaps; running sum 95,15F,205,2F8,3EB,447
        begin_frame(8'd7);
        for (int i = 0; i < 7; i++) begin
            send_beat(t2[i]);
            if (i == 2 || i == 4) begin
                step();
                step();
            end
        end
        check_eq("t2_out_valid", 32'(out_valid), 32'd1);
        check_eq("t2_out_sum",   32'(out_sum),   32'h0447);
        check_eq("t2_out_ovf",   32'(out_ovf),   32'd0);
        check_eq("t2_sum9",      32'(out_sum9),  32'h047);
        check_eq("t2_ovf9",      32'(out_ovf9),  32'd1);
        drain();

        // 3: empty frame
        begin_frame(8'd0);
        check_eq("t3_out_valid", 32'(out_valid), 32'd1);
        check_eq("t3_out_sum",   32'(out_sum),   32'd0);
        check_eq("t3_out_ovf",   32'(out_ovf),   32'd0);
        check_eq("t3_in_ready",  32'(in_ready),  32'd0);
        in_valid = 1'b1; in_data = 8'h55;
        step();
        in_valid = 1'b0;
        check_eq("t3_still_sum", 32'(out_sum), 32'd0);
        drain();

        // 4: three 0xFF beats; 9-bit wraps to 0x0FD with overflow
        begin_frame(8'd3);
        repeat (3) send_beat(8'hFF);
        check_eq("t4_valid9", 32'(out_valid9), 32'd1);
        check_eq("t4_sum9",   32'(out_sum9),   32'h0FD);
        check_eq("t4_ovf9",   32'(out_ovf9),   32'd1);
        check_eq("t4_sum16",  32'(out_sum),    32'h02FD);
        check_eq("t4_ovf16",  32'(out_ovf),    32'd0);
        drain();

        // 5: held result stays stable, start ignored while holding
        begin_frame(8'd1);
        send_beat(8'h10);
        for (int i = 0; i < 5; i++) begin
            start     = (i % 2 == 0);
            frame_len = 8'd3;
            step();
            check_eq("t5_hold_valid", 32'(out_valid), 32'd1);
            check_eq("t5_hold_sum",   32'(out_sum),   32'h0010);
            check_eq("t5_hold_rdy",   32'(in_ready),  32'd0);
        end
        start     = 1'b1;
        frame_len = 8'd2;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("t5_exit_valid", 32'(out_valid), 32'd0);
        check_eq("t5_exit_busy",  32'(busy),      32'd0);
        step();
        start = 1'b0;
        check_eq("t5_restart_rdy", 32'(in_ready), 32'd1);
        send_beat(8'h20);
        send_beat(8'h30);
        check_eq("t5_new_valid", 32'(out_valid), 32'd1);
        check_eq("t5_new_sum",   32'(out_sum),   32'h0050);
        drain();

        // 6: reset mid-frame abandons it
        begin_frame(8'd4);
        send_beat(8'h11);
        send_beat(8'h22);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t6_rst_rdy",   32'(in_ready),  32'd0);
        check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
        check_eq("t6_rst_sum",   32'(out_sum),   32'd0);
        check_eq("t6_rst_ovf",   32'(out_ovf),   32'd0);
        check_eq("t6_rst_busy",  32'(busy),      32'd0);
        check_eq("t6_rst_busy9", 32'(busy9),     32'd0);
        step();
        check_eq("t6_no_result", 32'(out_valid), 32'd0);
        begin_frame(8'd2);
        check_eq("t6_rdy9", 32'(in_ready9), 32'd1);
        send_beat(8'h01);
        send_beat(8'h02);
        check_eq("t6_out_valid", 32'(out_valid), 32'd1);
        check_eq("t6_out_sum",   32'(out_sum),   32'h0003);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
